// File: rtl/axi_lite_audio_slave.sv
// AXI4-Lite slave with four 32-bit registers (CTRL, SAMPLE, DIV, USER) driving
// a single-entry audio stream output. A divider tick latches SAMPLE into the
// stream register; a tick that cannot be delivered sets the sticky CTRL[31].
module axi_lite_audio_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     audio_tdata,
    output logic                              audio_tvalid,
    input  logic                              audio_tready
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_LSB = 2;

    logic [DW-1:0] ctrl_reg, sample_reg, div_reg, user_reg;
    logic [DW-1:0] ctrl_nxt;
    logic [DW-1:0] rd_mux;
    logic [DW-1:0] tick_cnt;
    logic [DW-1:0] div_thr;
    logic [1:0]    wr_sel, rd_sel;
    logic          wr_en, rd_en, tick, overrun;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [DW/8-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < DW/8; i++)
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    assign wr_sel = s00_axi_awaddr[ADDR_LSB+1:ADDR_LSB];
    assign rd_sel = s00_axi_araddr[ADDR_LSB+1:ADDR_LSB];
    // awready and wready always move together, so one of them qualifies the write.
    assign wr_en  = s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid;
    assign rd_en  = s00_axi_arready && s00_axi_arvalid;

    // DIV of 0 behaves like 1: a tick every enabled cycle.
    assign div_thr = (div_reg == '0) ? '0 : div_reg - DW'(1);
    assign tick    = ctrl_reg[0] && (tick_cnt >= div_thr);
    // A tick only overruns if the held sample is not leaving this same cycle.
    assign overrun = tick && audio_tvalid && !audio_tready;

    // CTRL next value: software write first, then the sticky overrun flag wins.
    always_comb begin
        ctrl_nxt = ctrl_reg;
        if (wr_en && wr_sel == 2'd0)
            ctrl_nxt = apply_strb(ctrl_reg, s00_axi_wdata, s00_axi_wstrb);
        if (overrun)
            ctrl_nxt[DW-1] = 1'b1;
    end

    // Read data mux; sampled at the AR handshake so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            2'd0: rd_mux = ctrl_reg;
            2'd1: rd_mux = sample_reg;
            2'd2: rd_mux = div_reg;
            2'd3: rd_mux = user_reg;
            default: rd_mux = '0;
        endcase
    end

    // Write address/data acceptance and write response.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= 2'b00;
        end else begin
            if (!s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) begin
                s00_axi_awready <= 1'b1;
                s00_axi_wready  <= 1'b1;
            end else begin
                s00_axi_awready <= 1'b0;
                s00_axi_wready  <= 1'b0;
            end
            s00_axi_bresp <= 2'b00;
            if (wr_en)
                s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bvalid && s00_axi_bready)
                s00_axi_bvalid <= 1'b0;
        end
    end

    // Register file updates.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            ctrl_reg   <= '0;
            sample_reg <= '0;
            div_reg    <= '0;
            user_reg   <= '0;
        end else begin
            ctrl_reg <= ctrl_nxt;
            if (wr_en && wr_sel == 2'd1) sample_reg <= apply_strb(sample_reg, s00_axi_wdata, s00_axi_wstrb);
            if (wr_en && wr_sel == 2'd2) div_reg    <= apply_strb(div_reg, s00_axi_wdata, s00_axi_wstrb);
            if (wr_en && wr_sel == 2'd3) user_reg   <= apply_strb(user_reg, s00_axi_wdata, s00_axi_wstrb);
        end
    end

    // Read address acceptance and read data channel.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= 2'b00;
        end else begin
            s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
            s00_axi_rresp   <= 2'b00;
            if (rd_en) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    // Sample-rate divider: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset)
            tick_cnt <= '0;
        else if (!ctrl_reg[0] || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + DW'(1);
    end

    // Audio output register: load on tick when empty or draining, else hold until taken.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            audio_tvalid <= 1'b0;
            audio_tdata  <= '0;
        end else if (tick && (!audio_tvalid || audio_tready)) begin
            audio_tvalid <= 1'b1;
            audio_tdata  <= sample_reg;
        end else if (audio_tvalid && audio_tready) begin
            audio_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_audio_slave.sv
// Self-checking bench for axi_lite_audio_slave: register map behaviour against
// a byte-masked array model, plus audio tick / overrun / reset scenarios.
module tb_axi_lite_audio_slave;
    logic        tb_ACLK = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, audio_tdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        audio_tvalid, audio_tready;

    int total = 0;
    int bad   = 0;
    int tv_cnt = 0;
    logic [31:0] model [4];

    always #5 tb_ACLK = ~tb_ACLK;

    // Cycles during which the audio output showed valid data.
    always @(posedge tb_ACLK) if (audio_tvalid) tv_cnt <= tv_cnt + 1;

    axi_lite_audio_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .s00_axi_aclk(tb_ACLK), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .audio_tdata(audio_tdata), .audio_tvalid(audio_tvalid), .audio_tready(audio_tready)
    );

    function automatic logic [31:0] strb_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge tb_ACLK); #1; end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!awready && n < 50);
        if (!awready) begin
            total++; bad++;
            $display("FAIL aw_timeout addr=%h got awready=%b want 1", a, awready);
            awvalid = 0; wvalid = 0; resp = 2'b11;
            return;
        end
        @(posedge tb_ACLK); #1;
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge tb_ACLK); #1; n++; end
        if (!bvalid) begin
            total++; bad++;
            $display("FAIL b_timeout addr=%h got bvalid=%b want 1", a, bvalid);
            resp = 2'b11;
            return;
        end
        resp = bresp;
        @(posedge tb_ACLK); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1; rready = 1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!arready && n < 50);
        if (!arready) begin
            total++; bad++;
            $display("FAIL ar_timeout addr=%h got arready=%b want 1", a, arready);
            arvalid = 0; d = 32'hx; resp = 2'b11;
            return;
        end
        @(posedge tb_ACLK); #1;
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge tb_ACLK); #1; n++; end
        if (!rvalid) begin
            total++; bad++;
            $display("FAIL r_timeout addr=%h got rvalid=%b want 1", a, rvalid);
            d = 32'hx; resp = 2'b11;
            return;
        end
        d = rdata; resp = rresp;
        @(posedge tb_ACLK); #1;
    endtask

    // Write through the bus, keep the model in step and check the response code.
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        axi_write(a, d, s, r);
        model[a[3:2]] = strb_merge(model[a[3:2]], d, s);
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL bresp addr=%h got %b want 00", a, r); end
    endtask

    // Read through the bus and compare with an explicit expected value.
    task automatic rd_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        total++;
        if (d !== exp || r !== 2'b00) begin
            bad++;
            $display("FAIL %s addr=%h got %h/%b want %h/00", nm, a, d, r, exp);
        end
    endtask

    task automatic wait_tvalid(input string nm, output bit ok);
        int n;
        n = 0;
        while (!audio_tvalid && n < 300) begin @(posedge tb_ACLK); #1; n++; end
        ok = audio_tvalid;
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_tvalid_timeout got tvalid=0 want 1", nm);
        end
    endtask

    task automatic test_reset;
        cyc(3);
        total++;
        if ({awready, wready, bvalid, arready, rvalid, audio_tvalid} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got %b want 000000", {awready, wready, bvalid, arready, rvalid, audio_tvalid});
        end
        total++;
        if ({bresp, rresp, rdata, audio_tdata} !== 68'b0) begin
            bad++; $display("FAIL reset_data got b=%b r=%b rd=%h td=%h want zeros", bresp, rresp, rdata, audio_tdata);
        end
        @(negedge tb_ACLK); rst = 0;
        cyc(1);
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        rd_check("reset_ctrl", 4'h0, 32'h0);
        rd_check("reset_div", 4'h8, 32'h0);
    endtask

    task automatic test_regs;
        audio_tready = 1;
        wr(4'h0, 32'h0101FFFF, 4'hF);
        wr(4'h4, 32'hABCD0001, 4'hF);
        wr(4'h8, 32'hDEAD0011, 4'hF);
        wr(4'hC, 32'hBEEF0011, 4'hF);
        rd_check("rb_ctrl",   4'h0, 32'h0101FFFF);
        rd_check("rb_sample", 4'h4, 32'hABCD0001);
        rd_check("rb_div",    4'h8, 32'hDEAD0011);
        rd_check("rb_user",   4'hC, 32'hBEEF0011);
        wr(4'hC, 32'hFFFFFFFF, 4'hF);
        wr(4'hC, 32'h12345678, 4'b0101);
        rd_check("strb_user", 4'hC, 32'hFF34FF78);
        wr(4'h0, 32'h0, 4'hF);
    endtask

    task automatic test_random_regs;
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        audio_tready = 1;
        for (int i = 0; i < 40; i++) begin
            a = 2'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(15, 0));
                wr({a, 2'($urandom_range(3, 0))}, d, s);
            end else begin
                rd_check("rand_rd", {a, 2'b00}, model[a]);
            end
        end
        wr(4'h0, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) rd_check("rand_final", 4'(i * 4), model[i]);
    endtask

    task automatic test_same_cycle;
        logic [31:0] oldv, newv;
        int n;
        oldv = model[3];
        newv = ~oldv ^ 32'h5A5A0000;
        awaddr = 4'hC; wdata = newv; wstrb = 4'hF; araddr = 4'hC;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!(awready && arready) && n < 20);
        total++;
        if (!(awready && arready)) begin
            bad++; $display("FAIL same_cycle_accept got aw=%b ar=%b want 1 1", awready, arready);
        end
        @(posedge tb_ACLK); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        total++;
        if (!rvalid || rdata !== oldv) begin
            bad++; $display("FAIL same_cycle_rdata got %h (rvalid=%b) want %h", rdata, rvalid, oldv);
        end
        cyc(2);
        model[3] = newv;
        rd_check("same_cycle_after", 4'hC, newv);
    endtask

    task automatic test_back_to_back;
        logic [31:0] w1, w2;
        int n, errs;
        w1 = $urandom; w2 = $urandom;
        bready = 0;
        awaddr = 4'hC; wdata = w1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!awready && n < 20);
        @(posedge tb_ACLK); #1;
        awvalid = 0; wvalid = 0;
        total++;
        if (!bvalid || bresp !== 2'b00) begin
            bad++; $display("FAIL bhold_first got bvalid=%b bresp=%b want 1 00", bvalid, bresp);
        end
        wdata = w2; awvalid = 1; wvalid = 1;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge tb_ACLK); #1;
            if (!bvalid || awready || wready) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL bhold_block got %0d bad cycles want 0", errs);
        end
        bready = 1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!awready && n < 20);
        total++;
        if (!awready) begin bad++; $display("FAIL bhold_second_accept got awready=0 want 1"); end
        @(posedge tb_ACLK); #1;
        awvalid = 0; wvalid = 0;
        cyc(2);
        model[3] = w2;
        rd_check("bhold_user", 4'hC, w2);
    endtask

    task automatic test_audio_rate;
        int d, prev, pulses;
        logic [31:0] s;
        bit ok;
        audio_tready = 1;
        for (int k = 0; k < 4; k++) begin
            d = (k == 0) ? 4 : int'($urandom_range(9, 2));
            s = (k == 0) ? 32'h0000A5A5 : $urandom;
            wr(4'h4, s, 4'hF);
            wr(4'h8, 32'(d), 4'hF);
            wr(4'h0, 32'h1, 4'hF);
            prev = -1; pulses = 0;
            for (int c = 0; c < 200 && pulses < 4; c++) begin
                @(posedge tb_ACLK); #1;
                if (audio_tvalid) begin
                    total++;
                    if (audio_tdata !== s) begin
                        bad++; $display("FAIL rate_tdata got %h want %h", audio_tdata, s);
                    end
                    if (prev >= 0) begin
                        total++;
                        if (c - prev != d) begin
                            bad++; $display("FAIL rate_period div=%0d got %0d want %0d", d, c - prev, d);
                        end
                    end
                    prev = c; pulses++;
                end
            end
            ok = (pulses == 4);
            if (!ok) begin total++; bad++; $display("FAIL rate_pulses got %0d want 4", pulses); end
            rd_check("rate_ctrl", 4'h0, 32'h1);
            wr(4'h0, 32'h0, 4'hF);
        end
    endtask

    task automatic test_reload;
        logic [31:0] s1, s2;
        int lows;
        bit ok;
        s1 = $urandom; s2 = ~s1;
        audio_tready = 1;
        wr(4'h4, s1, 4'hF);
        wr(4'h8, 32'h1, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        wait_tvalid("reload", ok);
        lows = 0;
        for (int i = 0; i < 6; i++) begin @(posedge tb_ACLK); #1; if (!audio_tvalid) lows++; end
        total++;
        if (lows != 0) begin bad++; $display("FAIL reload_continuous got %0d idle cycles want 0", lows); end
        wr(4'h4, s2, 4'hF);
        cyc(2);
        total++;
        if (!audio_tvalid || audio_tdata !== s2) begin
            bad++; $display("FAIL reload_newdata got %h (v=%b) want %h", audio_tdata, audio_tvalid, s2);
        end
        rd_check("reload_ctrl", 4'h0, 32'h1);
        wr(4'h0, 32'h0, 4'hF);
        cyc(2);
        total++;
        if (audio_tvalid !== 1'b0) begin bad++; $display("FAIL reload_stop got tvalid=%b want 0", audio_tvalid); end
    endtask

    task automatic test_overrun;
        logic [31:0] s1, s2;
        int errs, n;
        bit ok;
        s1 = $urandom; s2 = s1 ^ 32'h00FF00FF;
        audio_tready = 0;
        wr(4'h4, s1, 4'hF);
        wr(4'h8, 32'h2, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        wait_tvalid("overrun", ok);
        wr(4'h4, s2, 4'hF);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge tb_ACLK); #1;
            if (!audio_tvalid || audio_tdata !== s1) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL overrun_hold got %0d bad cycles want 0", errs); end
        rd_check("overrun_flag", 4'h0, 32'h80000001);
        audio_tready = 1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!(audio_tvalid && audio_tdata === s2) && n < 20);
        total++;
        if (!(audio_tvalid && audio_tdata === s2)) begin
            bad++; $display("FAIL overrun_next got %h want %h", audio_tdata, s2);
        end
        rd_check("overrun_sticky", 4'h0, 32'h80000001);
        wr(4'h0, 32'h1, 4'hF);
        rd_check("overrun_clear", 4'h0, 32'h1);
        wr(4'h0, 32'h0, 4'hF);
        cyc(2);
    endtask

    task automatic test_div_change;
        int snap;
        audio_tready = 1;
        wr(4'h8, 32'd100, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        snap = tv_cnt;
        cyc(20);
        total++;
        if (tv_cnt != snap) begin bad++; $display("FAIL div_early got %0d pulses want 0", tv_cnt - snap); end
        wr(4'h8, 32'd5, 4'hF);
        cyc(1);
        total++;
        if (tv_cnt == snap) begin bad++; $display("FAIL div_immediate got 0 pulses want >0"); end
        wr(4'h0, 32'h0, 4'hF);
        cyc(2);
    endtask

    task automatic test_disable_pending;
        logic [31:0] s;
        int errs, snap;
        bit ok;
        s = $urandom;
        audio_tready = 0;
        wr(4'h4, s, 4'hF);
        wr(4'h8, 32'h3, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        wait_tvalid("disable", ok);
        wr(4'h0, 32'h0, 4'hF);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge tb_ACLK); #1;
            if (!audio_tvalid || audio_tdata !== s) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL disable_pending got %0d bad cycles want 0", errs); end
        audio_tready = 1;
        cyc(1);
        total++;
        if (audio_tvalid !== 1'b0) begin bad++; $display("FAIL disable_drain got tvalid=%b want 0", audio_tvalid); end
        snap = tv_cnt;
        cyc(10);
        total++;
        if (tv_cnt != snap) begin bad++; $display("FAIL disable_quiet got %0d pulses want 0", tv_cnt - snap); end
        wr(4'h0, 32'h0, 4'hF);
        rd_check("disable_ctrl", 4'h0, 32'h0);
    endtask

    task automatic test_reset_midop;
        int n;
        bit ok;
        audio_tready = 0;
        wr(4'h4, 32'hCAFEF00D, 4'hF);
        wr(4'h8, 32'h2, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        wait_tvalid("midrst", ok);
        rready = 0;
        araddr = 4'h4; arvalid = 1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!arready && n < 20);
        @(posedge tb_ACLK); #1;
        arvalid = 0;
        total++;
        if (!rvalid || !audio_tvalid) begin
            bad++; $display("FAIL midrst_setup got rvalid=%b tvalid=%b want 1 1", rvalid, audio_tvalid);
        end
        #2 rst = 1;
        #1;
        total++;
        if (rvalid !== 1'b0 || audio_tvalid !== 1'b0 || rdata !== 32'h0 || audio_tdata !== 32'h0) begin
            bad++; $display("FAIL midrst_async got rv=%b tv=%b rd=%h td=%h want 0", rvalid, audio_tvalid, rdata, audio_tdata);
        end
        cyc(2);
        @(negedge tb_ACLK); rst = 0;
        audio_tready = 1;
        cyc(3);
        total++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || audio_tvalid !== 1'b0) begin
            bad++; $display("FAIL midrst_after got rv=%b bv=%b tv=%b want 0", rvalid, bvalid, audio_tvalid);
        end
        for (int i = 0; i < 4; i++) rd_check("midrst_reg", 4'(i * 4), 32'h0);
    endtask

    initial begin
        rst = 1;
        awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        wdata = 0; wstrb = 0; audio_tready = 1;
        test_reset;
        test_regs;
        test_random_regs;
        test_same_cycle;
        test_back_to_back;
        test_audio_rate;
        test_reload;
        test_overrun;
        test_div_change;
        test_disable_pending;
        test_reset_midop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
